// File: rtl/id_ex_ctrl_stage_pkg.sv
// Shared RV32IM control definitions: opcodes, immediate formats, ALU codes and the
// ID/EX control bundle.
package id_ex_ctrl_stage_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULT = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_U = 3'b010,
        IMM_B = 3'b011,
        IMM_J = 3'b100
    } imm_type_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_XOR    = 5'b00001,
        ALU_AND    = 5'b00010,
        ALU_OR     = 5'b00011,
        ALU_MUL    = 5'b00100,
        ALU_MULH   = 5'b00101,
        ALU_MULHU  = 5'b00110,
        ALU_DIV    = 5'b01000,
        ALU_DIVU   = 5'b01001,
        ALU_REM    = 5'b01010,
        ALU_MULHSU = 5'b01011,
        ALU_REMU   = 5'b01100,
        ALU_SLL    = 5'b01101,
        ALU_SRA    = 5'b01110,
        ALU_SLT    = 5'b01111,
        ALU_SUB    = 5'b10000,
        ALU_SLTU   = 5'b10001,
        ALU_SRL    = 5'b10010,
        ALU_PASSB  = 5'b10011
    } alu_op_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       pc_sel;
        logic       imm_sel;
        logic       wb_sel;
        imm_type_e  imm_type;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jal;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       illegal;
    } ctrl_t;

    // Base-ISA op for funct7=0000000; shifts right default to logical.
    function automatic alu_op_e base_alu(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e m_alu(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_ctrl_stage_ctrl_decode.sv
// Combinational RV32IM decoder: instruction word to control bundle plus the
// register-usage flags needed by the load-use hazard check.
module ctrl_decode
    import id_ex_ctrl_stage_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ctrl_o        = '0;
        ctrl_o.funct3 = funct3;
        ctrl_o.rs1    = instr_i[19:15];
        ctrl_o.rs2    = instr_i[24:20];
        ctrl_o.rd     = instr_i[11:7];
        uses_rs1_o    = 1'b1;
        uses_rs2_o    = 1'b0;
        bad           = 1'b0;

        case (opcode)
            OP_REG: begin
                uses_rs2_o       = 1'b1;
                ctrl_o.reg_write = 1'b1;
                case (funct7)
                    F7_BASE: ctrl_o.alu_op = base_alu(funct3);
                    F7_ALT: begin
                        if (funct3 == 3'b000)      ctrl_o.alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) ctrl_o.alu_op = ALU_SRA;
                        else                       bad = 1'b1;
                    end
                    F7_MULT: begin
                        if (EN_M) ctrl_o.alu_op = m_alu(funct3);
                        else      bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                ctrl_o.imm_sel   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = base_alu(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    bad = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       ctrl_o.alu_op = ALU_SRA;
                    else if (funct7 != F7_BASE) bad = 1'b1;
                end
            end
            OP_LOAD: begin
                ctrl_o.imm_sel   = 1'b1;
                ctrl_o.wb_sel    = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_STORE: begin
                uses_rs2_o       = 1'b1;
                ctrl_o.imm_sel   = 1'b1;
                ctrl_o.imm_type  = IMM_S;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs2_o      = 1'b1;
                ctrl_o.pc_sel   = 1'b1;
                ctrl_o.imm_sel  = 1'b1;
                ctrl_o.imm_type = IMM_B;
                ctrl_o.branch   = 1'b1;
            end
            OP_JAL: begin
                uses_rs1_o       = 1'b0;
                ctrl_o.pc_sel    = 1'b1;
                ctrl_o.imm_sel   = 1'b1;
                ctrl_o.imm_type  = IMM_J;
                ctrl_o.jump      = 1'b1;
                ctrl_o.jal       = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_JALR: begin
                ctrl_o.imm_sel   = 1'b1;
                ctrl_o.jump      = 1'b1;
                ctrl_o.jal       = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                uses_rs1_o       = 1'b0;
                ctrl_o.pc_sel    = 1'b1;
                ctrl_o.imm_sel   = 1'b1;
                ctrl_o.imm_type  = IMM_U;
                ctrl_o.reg_write = 1'b1;
            end
            OP_LUI: begin
                uses_rs1_o       = 1'b0;
                ctrl_o.alu_op    = ALU_PASSB;
                ctrl_o.imm_sel   = 1'b1;
                ctrl_o.imm_type  = IMM_U;
                ctrl_o.reg_write = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        // An illegal word travels as a harmless ADD with all enables off; EX raises the trap.
        if (bad) begin
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.pc_sel    = 1'b0;
            ctrl_o.imm_sel   = 1'b0;
            ctrl_o.wb_sel    = 1'b0;
            ctrl_o.imm_type  = IMM_I;
            ctrl_o.reg_write = 1'b0;
            ctrl_o.mem_read  = 1'b0;
            ctrl_o.mem_write = 1'b0;
            ctrl_o.branch    = 1'b0;
            ctrl_o.jump      = 1'b0;
            ctrl_o.jal       = 1'b0;
            ctrl_o.illegal   = 1'b1;
            uses_rs1_o       = 1'b0;
            uses_rs2_o       = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX stage: decodes the IF/ID instruction and holds the control bundle for EX,
// with valid/ready handshake, load-use bubbles and flush.
module id_ex_ctrl_stage
    import id_ex_ctrl_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit EN_M       = 1'b1,
    parameter bit EN_LOADUSE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_alu_op,
    output logic            ex_pc_sel,
    output logic            ex_imm_sel,
    output logic            ex_wb_sel,
    output logic [2:0]      ex_imm_type,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_jal,
    output logic [2:0]      ex_funct3,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_illegal
);

    ctrl_t           dec;
    logic            uses_rs1;
    logic            uses_rs2;
    ctrl_t           ctrl_q, ctrl_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            hazard;
    logic            update;

    ctrl_decode #(.EN_M(EN_M)) u_decode (
        .instr_i    (if_instr),
        .ctrl_o     (dec),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2)
    );

    assign hazard = EN_LOADUSE && valid_q && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) &&
                    ((uses_rs1 && (dec.rs1 == ctrl_q.rd)) ||
                     (uses_rs2 && (dec.rs2 == ctrl_q.rd)));

    assign id_ready = !reset && !flush && !hazard && (!valid_q || ex_ready);
    assign update   = !valid_q || ex_ready || flush;

    // Flush and hazard both force id_ready low, so any non-accepting update is a bubble.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        if (update) begin
            if (if_valid && id_ready) begin
                valid_d = 1'b1;
                ctrl_d  = dec;
                pc_d    = if_pc;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                pc_d    = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_alu_op    = ctrl_q.alu_op;
    assign ex_pc_sel    = ctrl_q.pc_sel;
    assign ex_imm_sel   = ctrl_q.imm_sel;
    assign ex_wb_sel    = ctrl_q.wb_sel;
    assign ex_imm_type  = ctrl_q.imm_type;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_branch    = ctrl_q.branch;
    assign ex_jump      = ctrl_q.jump;
    assign ex_jal       = ctrl_q.jal;
    assign ex_funct3    = ctrl_q.funct3;
    assign ex_rs1       = ctrl_q.rs1;
    assign ex_rs2       = ctrl_q.rs2;
    assign ex_rd        = ctrl_q.rd;
    assign ex_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage: one EN_M=1 instance and one EN_M=0 instance
// share the same stimulus.
module tb_id_ex_ctrl_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_ready;

    logic        id_ready, ex_valid, ex_pc_sel, ex_imm_sel, ex_wb_sel, ex_reg_write;
    logic        ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_jal, ex_illegal;
    logic [31:0] ex_pc;
    logic [4:0]  ex_alu_op, ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_imm_type, ex_funct3;

    logic        n_id_ready, n_ex_valid, n_ex_pc_sel, n_ex_imm_sel, n_ex_wb_sel, n_ex_reg_write;
    logic        n_ex_mem_read, n_ex_mem_write, n_ex_branch, n_ex_jump, n_ex_jal, n_ex_illegal;
    logic [31:0] n_ex_pc;
    logic [4:0]  n_ex_alu_op, n_ex_rs1, n_ex_rs2, n_ex_rd;
    logic [2:0]  n_ex_imm_type, n_ex_funct3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_ctrl_stage #(.XLEN(32), .EN_M(1'b1), .EN_LOADUSE(1'b1)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_alu_op(ex_alu_op), .ex_pc_sel(ex_pc_sel), .ex_imm_sel(ex_imm_sel),
        .ex_wb_sel(ex_wb_sel), .ex_imm_type(ex_imm_type), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_jal(ex_jal), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_illegal(ex_illegal)
    );

    id_ex_ctrl_stage #(.XLEN(32), .EN_M(1'b0), .EN_LOADUSE(1'b1)) dut_nom (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(n_id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(n_ex_valid),
        .ex_pc(n_ex_pc), .ex_alu_op(n_ex_alu_op), .ex_pc_sel(n_ex_pc_sel),
        .ex_imm_sel(n_ex_imm_sel), .ex_wb_sel(n_ex_wb_sel), .ex_imm_type(n_ex_imm_type),
        .ex_reg_write(n_ex_reg_write), .ex_mem_read(n_ex_mem_read),
        .ex_mem_write(n_ex_mem_write), .ex_branch(n_ex_branch), .ex_jump(n_ex_jump),
        .ex_jal(n_ex_jal), .ex_funct3(n_ex_funct3), .ex_rs1(n_ex_rs1), .ex_rs2(n_ex_rs2),
        .ex_rd(n_ex_rd), .ex_illegal(n_ex_illegal)
    );

    task automatic check(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h402081B3;
        if_pc    = 32'h100;

        // Reset with a valid instruction presented: nothing gets in.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_all_zero",
                  {ex_valid, ex_pc, ex_alu_op, ex_pc_sel, ex_imm_sel, ex_wb_sel, ex_imm_type,
                   ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_jal,
                   ex_funct3, ex_rs1, ex_rs2, ex_rd, ex_illegal}, 96'd0);
            check("rst_id_ready", id_ready, 0);
        end
        reset    = 1'b0;
        if_valid = 1'b0;
        #1;
        check("ready_after_rst", id_ready, 1);

        // sub x3,x1,x2
        if_valid = 1'b1;
        if_instr = 32'h402081B3;
        if_pc    = 32'h100;
        tick();
        check("sub_valid", ex_valid, 1);
        check("sub_alu", ex_alu_op, 5'b10000);
        check("sub_regw", ex_reg_write, 1);
        check("sub_rd", ex_rd, 3);
        check("sub_imm_sel", ex_imm_sel, 0);
        check("sub_pc", ex_pc, 32'h100);

        // srai x1,x1,3 back to back
        if_instr = 32'h4030D093;
        if_pc    = 32'h104;
        tick();
        check("srai_valid", ex_valid, 1);
        check("srai_alu", ex_alu_op, 5'b01110);
        check("srai_imm_sel", ex_imm_sel, 1);
        check("srai_rd", ex_rd, 1);

        // lw x5,0(x1) then dependent add x6,x5,x5
        if_instr = 32'h0000A283;
        if_pc    = 32'h108;
        tick();
        check("lw_valid", ex_valid, 1);
        check("lw_mem_read", ex_mem_read, 1);
        check("lw_wb_sel", ex_wb_sel, 1);
        check("lw_rd", ex_rd, 5);
        if_instr = 32'h00528333;
        if_pc    = 32'h10C;
        #1;
        check("hazard_ready", id_ready, 0);
        tick();
        check("bubble_valid", ex_valid, 0);
        check("bubble_mem_read", ex_mem_read, 0);
        check("post_bubble_ready", id_ready, 1);
        tick();
        check("add_valid", ex_valid, 1);
        check("add_rd", ex_rd, 6);
        check("add_alu", ex_alu_op, 5'b00000);
        check("add_pc", ex_pc, 32'h10C);

        // Backpressure for 3 cycles while holding add
        ex_ready = 1'b0;
        if_instr = 32'h402081B3;
        if_pc    = 32'h110;
        #1;
        check("stall_ready", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", ex_valid, 1);
            check("stall_bundle", {ex_pc, ex_rd, ex_rs1, ex_rs2, ex_alu_op, ex_reg_write},
                  {32'h10C, 5'd6, 5'd5, 5'd5, 5'd0, 1'b1});
            check("stall_id_ready", id_ready, 0);
        end
        ex_ready = 1'b1;
        #1;
        check("resume_ready", id_ready, 1);
        tick();
        check("resume_rd", ex_rd, 3);
        check("resume_pc", ex_pc, 32'h110);

        // Flush while holding sub and presenting addi x9,x0,5
        flush    = 1'b1;
        if_instr = 32'h00500493;
        if_pc    = 32'h114;
        #1;
        check("flush_ready", id_ready, 0);
        tick();
        check("flush_valid", ex_valid, 0);
        flush    = 1'b0;
        if_valid = 1'b0;
        tick();
        check("flush_dropped", ex_valid, 0);

        // mul x3,x1,x2 on both configurations
        if_valid = 1'b1;
        if_instr = 32'h022081B3;
        if_pc    = 32'h118;
        tick();
        check("mul_alu", ex_alu_op, 5'b00100);
        check("mul_illegal", ex_illegal, 0);
        check("mul_regw", ex_reg_write, 1);
        check("nom_mul_illegal", n_ex_illegal, 1);
        check("nom_mul_valid", n_ex_valid, 1);
        check("nom_mul_regw", n_ex_reg_write, 0);
        check("nom_mul_alu", n_ex_alu_op, 5'b00000);

        // Unknown opcode 0x7F
        if_instr = 32'h0000007F;
        if_pc    = 32'h11C;
        tick();
        check("op7f_illegal", ex_illegal, 1);
        check("op7f_valid", ex_valid, 1);
        check("op7f_enables", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump}, 5'd0);
        check("nom_op7f_illegal", n_ex_illegal, 1);

        // slli with funct7=0100000 is illegal
        if_instr = 32'h40309093;
        if_pc    = 32'h120;
        tick();
        check("slli_bad_illegal", ex_illegal, 1);
        check("slli_bad_regw", ex_reg_write, 0);

        // lui x1,0x12345
        if_instr = 32'h123450B7;
        if_pc    = 32'h124;
        tick();
        check("lui_alu", ex_alu_op, 5'b10011);
        check("lui_imm_type", ex_imm_type, 3'b010);
        check("lui_sel", {ex_pc_sel, ex_imm_sel, ex_reg_write, ex_illegal}, 4'b0110);

        // Load into x0 never stalls a consumer of x0
        if_instr = 32'h0000A003;
        if_pc    = 32'h128;
        tick();
        check("lw_x0_mem_read", ex_mem_read, 1);
        if_instr = 32'h00000333;
        if_pc    = 32'h12C;
        #1;
        check("x0_no_hazard", id_ready, 1);
        tick();
        check("x0_add_valid", ex_valid, 1);
        check("x0_add_rd", ex_rd, 6);

        if_valid = 1'b0;
        tick();
        check("idle_valid", ex_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
